// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use, mispredict, ret, memory-wait and
// exception draining, with a run/memwait/drain/halt FSM and performance counters.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [3:0]  D_icode_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    input  logic [3:0]  E_icode_i,
    input  logic [3:0]  E_dstM_i,
    input  logic        e_Cnd_i,
    input  logic [3:0]  M_icode_i,
    input  logic [2:0]  m_stat_i,
    input  logic [2:0]  W_stat_i,
    input  logic        dmem_busy_i,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        D_bubble_o,
    output logic        E_stall_o,
    output logic        E_bubble_o,
    output logic        M_stall_o,
    output logic        M_bubble_o,
    output logic        W_stall_o,
    output logic        W_bubble_o,
    output logic        set_cc_o,
    output logic        cpu_halt_o,
    output logic        bus_err_o,
    output logic [1:0]  state_o,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] stall_cnt_o
);

    // Y86-64 instruction, register and status encodings
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] STAT_BUBBLE = 3'd0;
    localparam logic [2:0] STAT_AOK    = 3'd1;

    localparam int unsigned WAIT_W =
        ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_e;

    state_e              state_q, state_nxt;
    logic [WAIT_W-1:0]   wait_q, wait_nxt;
    logic                bus_err_q, bus_err_nxt;
    logic                cpu_halt_q;
    logic [31:0]         cycle_q, stall_q;

    logic load_use, mispredict, ret_pend, mem_acc, mem_wait, m_exc, w_exc;

    always_comb begin
        load_use   = (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && (E_dstM_i != RNONE)
                     && (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
        mispredict = (E_icode_i == IJXX) && !e_Cnd_i;
        ret_pend   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mem_acc    = (M_icode_i == IMRMOVQ) || (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ)
                     || (M_icode_i == IPOPQ) || (M_icode_i == ICALL) || (M_icode_i == IRET);
        mem_wait   = mem_acc && dmem_busy_i;
        m_exc      = (m_stat_i != STAT_AOK) && (m_stat_i != STAT_BUBBLE);
        w_exc      = (W_stat_i != STAT_AOK) && (W_stat_i != STAT_BUBBLE);
    end

    // Next state, pipeline controls and wait-counter update
    always_comb begin
        F_stall_o   = 1'b0;
        D_stall_o   = 1'b0;
        D_bubble_o  = 1'b0;
        E_stall_o   = 1'b0;
        E_bubble_o  = 1'b0;
        M_stall_o   = 1'b0;
        M_bubble_o  = 1'b0;
        W_stall_o   = 1'b0;
        W_bubble_o  = 1'b0;
        set_cc_o    = 1'b0;
        state_nxt   = state_q;
        bus_err_nxt = bus_err_q;

        case (state_q)
            RUN, MEMWAIT: begin
                if (mem_wait) begin
                    F_stall_o  = 1'b1;
                    D_stall_o  = 1'b1;
                    E_stall_o  = 1'b1;
                    M_stall_o  = 1'b1;
                    W_bubble_o = 1'b1;
                end else begin
                    F_stall_o  = load_use | ret_pend;
                    D_stall_o  = load_use;
                    D_bubble_o = mispredict | (ret_pend & ~load_use);
                    E_bubble_o = mispredict | load_use;
                end
                set_cc_o = (state_q == RUN) && !mem_wait && (E_icode_i == IOPQ)
                           && !m_exc && !w_exc;

                if (state_q == RUN && w_exc) begin
                    W_stall_o  = 1'b1;
                    W_bubble_o = 1'b0;
                    state_nxt  = HALT;
                end else if (m_exc) begin
                    state_nxt = DRAIN;
                end else if (mem_wait) begin
                    if (state_q == MEMWAIT && wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_nxt   = HALT;
                        bus_err_nxt = 1'b1;
                    end else begin
                        state_nxt = MEMWAIT;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            DRAIN: begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                M_bubble_o = 1'b1;
                if (w_exc) begin
                    W_stall_o = 1'b1;
                    state_nxt = HALT;
                end
            end
            default: begin
                F_stall_o = 1'b1;
                D_stall_o = 1'b1;
                E_stall_o = 1'b1;
                M_stall_o = 1'b1;
                W_stall_o = 1'b1;
            end
        endcase

        wait_nxt = (state_q == MEMWAIT && state_nxt == MEMWAIT) ? wait_q + WAIT_W'(1) : '0;

        // Controls are forced quiet while reset is held
        if (!rst_n_i) begin
            F_stall_o  = 1'b0;
            D_stall_o  = 1'b0;
            D_bubble_o = 1'b0;
            E_stall_o  = 1'b0;
            E_bubble_o = 1'b0;
            M_stall_o  = 1'b0;
            M_bubble_o = 1'b0;
            W_stall_o  = 1'b0;
            W_bubble_o = 1'b0;
            set_cc_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            wait_q     <= '0;
            bus_err_q  <= 1'b0;
            cpu_halt_q <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_nxt;
            wait_q     <= wait_nxt;
            bus_err_q  <= bus_err_nxt;
            cpu_halt_q <= (state_nxt == HALT);
            if (state_q != HALT) begin
                if (cycle_q != 32'hFFFF_FFFF) cycle_q <= cycle_q + 32'd1;
                if (F_stall_o && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign state_o     = state_q;
    assign cpu_halt_o  = cpu_halt_q;
    assign bus_err_o   = bus_err_q;
    assign cycle_cnt_o = cycle_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: hazards, memory wait/timeout,
// exception drain, halt and reset behaviour.
module tb_pipe_ctrl;

    localparam logic [3:0] INOP = 4'h1, IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6,
                           IJXX = 4'h7, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB,
                           RNONE = 4'hF;
    localparam logic [2:0] SBUB = 3'd0, SAOK = 3'd1, SADR = 3'd2, SINS = 3'd3;

    localparam logic [13:0] FS = 14'h2000, DS = 14'h1000, DB = 14'h0800, ES = 14'h0400,
                            EB = 14'h0200, MS = 14'h0100, MB = 14'h0080, WS = 14'h0040,
                            WB = 14'h0020, CC = 14'h0010, HLT = 14'h0008, BE = 14'h0004;
    localparam logic [13:0] S_RUN = 14'd0, S_MW = 14'd1, S_DR = 14'd2, S_HA = 14'd3;
    localparam logic [13:0] MEMSTALL = FS | DS | ES | MS | WB;
    localparam logic [13:0] ALLSTALL = FS | DS | ES | MS | WS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_Cnd, dmem_busy;
    logic [2:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble;
    logic        W_stall, W_bubble, set_cc, cpu_halt, bus_err;
    logic [1:0]  state;
    logic [31:0] cycle_cnt, stall_cnt;

    typedef struct {
        string       tag;
        logic [13:0] ctl;
        logic [31:0] cyc;
        logic [31:0] stl;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] m_cyc = 0, m_stl = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
        .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
        .dmem_busy_i(dmem_busy),
        .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
        .E_stall_o(E_stall), .E_bubble_o(E_bubble), .M_stall_o(M_stall),
        .M_bubble_o(M_bubble), .W_stall_o(W_stall), .W_bubble_o(W_bubble),
        .set_cc_o(set_cc), .cpu_halt_o(cpu_halt), .bus_err_o(bus_err),
        .state_o(state), .cycle_cnt_o(cycle_cnt), .stall_cnt_o(stall_cnt)
    );

    task automatic idle();
        D_icode = INOP; E_icode = INOP; M_icode = INOP;
        d_srcA = RNONE; d_srcB = RNONE; E_dstM = RNONE;
        e_Cnd = 1'b1; m_stat = SAOK; W_stat = SAOK; dmem_busy = 1'b0;
    endtask

    // Push expectation, compare DUT after inputs settle, then advance one clock
    task automatic step(input string tag, input logic [13:0] ctl);
        exp_t e;
        logic [13:0] got;
        sb.push_back('{tag, ctl, m_cyc, m_stl});
        #1;
        got = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble,
               W_stall, W_bubble, set_cc, cpu_halt, bus_err, state};
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (got === e.ctl) else begin
                errors++;
                $error("FAIL %s ctl observed=%h expected=%h", e.tag, got, e.ctl);
            end
            vectors++;
            assert (cycle_cnt === e.cyc) else begin
                errors++;
                $error("FAIL %s cycle_cnt observed=%0d expected=%0d", e.tag, cycle_cnt, e.cyc);
            end
            vectors++;
            assert (stall_cnt === e.stl) else begin
                errors++;
                $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.stl);
            end
        end
        if (!rst_n) begin
            m_cyc = 0;
            m_stl = 0;
        end else if (ctl[1:0] != 2'd3) begin
            m_cyc++;
            if ((ctl & FS) != 14'd0) m_stl++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("reset", S_RUN);
        rst_n = 1'b1;
        step("idle", S_RUN);
        E_icode = IOPQ;
        step("opq_setcc", CC | S_RUN);

        // Data and control hazards
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        step("load_use_a", FS | DS | EB | S_RUN);
        E_icode = IPOPQ; E_dstM = 4'd2; d_srcA = RNONE; d_srcB = 4'd2;
        step("load_use_popq_b", FS | DS | EB | S_RUN);
        E_icode = IMRMOVQ; E_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
        step("rnone_no_hazard", S_RUN);
        idle();
        E_icode = IJXX; e_Cnd = 1'b0; D_icode = IRET;
        step("mispredict_ret", FS | DB | EB | S_RUN);
        idle();
        E_icode = IJXX; e_Cnd = 1'b1;
        step("jxx_taken", S_RUN);
        idle();
        M_icode = IRET;
        step("ret_in_m", FS | DB | S_RUN);
        E_icode = IMRMOVQ; E_dstM = 4'd2; d_srcB = 4'd2;
        step("ret_and_load_use", FS | DS | EB | S_RUN);

        // Memory wait for three cycles
        idle();
        M_icode = IMRMOVQ; dmem_busy = 1'b1; E_icode = IOPQ;
        step("memwait_enter", MEMSTALL | S_RUN);
        step("memwait_1", MEMSTALL | S_MW);
        step("memwait_2", MEMSTALL | S_MW);
        dmem_busy = 1'b0;
        step("memwait_release", S_MW);
        step("memwait_back_run", CC | S_RUN);

        // Exception drain then halt
        idle();
        E_icode = IOPQ; m_stat = SADR;
        step("m_exc_run", S_RUN);
        m_stat = SBUB;
        step("drain", FS | DS | MB | S_DR);
        W_stat = SADR;
        step("drain_w_exc", FS | DS | MB | WS | S_DR);
        step("halt", ALLSTALL | HLT | S_HA);
        step("halt_frozen", ALLSTALL | HLT | S_HA);
        rst_n = 1'b0;
        step("reset_from_halt_pre", HLT | S_HA);
        idle();
        step("reset_from_halt_post", S_RUN);
        rst_n = 1'b1;
        step("after_reset_idle", S_RUN);

        // Memory timeout with MEM_TIMEOUT=4
        M_icode = IPUSHQ; dmem_busy = 1'b1;
        step("to_enter", MEMSTALL | S_RUN);
        step("to_mw1", MEMSTALL | S_MW);
        step("to_mw2", MEMSTALL | S_MW);
        step("to_mw3", MEMSTALL | S_MW);
        step("to_mw4", MEMSTALL | S_MW);
        step("to_halt", ALLSTALL | HLT | BE | S_HA);
        step("to_halt_frozen", ALLSTALL | HLT | BE | S_HA);
        rst_n = 1'b0;
        idle();
        step("to_reset_pre", HLT | BE | S_HA);
        step("to_reset_post", S_RUN);
        rst_n = 1'b1;

        // Exception beats memory wait
        M_icode = IMRMOVQ; dmem_busy = 1'b1; m_stat = SADR;
        step("exc_over_memwait", MEMSTALL | S_RUN);
        idle();
        m_stat = SBUB;
        step("exc_priority_drain", FS | DS | MB | S_DR);
        rst_n = 1'b0;
        step("reset_from_drain", S_DR);
        rst_n = 1'b1;
        idle();
        step("run_after_drain_reset", S_RUN);

        // Direct W exception from RUN
        E_icode = IOPQ; W_stat = SINS;
        step("w_exc_run", WS | S_RUN);
        step("w_exc_halt", ALLSTALL | HLT | S_HA);
        rst_n = 1'b0;
        idle();
        step("w_reset_pre", HLT | S_HA);
        rst_n = 1'b1;

        // Reset taking effect from MEMWAIT
        M_icode = IRMMOVQ; dmem_busy = 1'b1;
        step("rmw_enter", MEMSTALL | S_RUN);
        step("rmw_wait", MEMSTALL | S_MW);
        rst_n = 1'b0;
        step("reset_in_memwait", S_MW);
        rst_n = 1'b1;
        idle();
        step("run_after_memwait_reset", S_RUN);
        step("final_idle", S_RUN);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
